fitness_eval_ctrl: RTL and testbench

//  FPGA-side sequencer for one chromosome fitness evaluation. Handshakes with HPS PIOs (start/ready/done/feedback).

---
 rtl/fitness_eval_ctrl_pkg.sv | 23 ++
 rtl/fitness_eval_ctrl_if.sv | 33 +++
 rtl/fitness_eval_ctrl_seq_error_accum.sv | 33 +++
 rtl/fitness_eval_ctrl.sv | 110 +++++++++++
 tb/tb_fitness_eval_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fitness_eval_ctrl_pkg.sv
// Shared types and constants for the fitness-evaluation sequencer.
// Default sizing matches the HPS PIO map: 32 sequence words, 8 scored outputs.
package fitness_eval_pkg;

    localparam int SEQ_W        = 32;
    localparam int CNT_W        = 32;
    localparam int NUM_SEQ_DEF  = 32;
    localparam int NUM_OUT_DEF  = 8;
    localparam int SETTLE_DEF   = 4;
    localparam int IDX_W        = $clog2(NUM_SEQ_DEF);

    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_SAMPLE,
        S_DONE,
        S_RELEASE
    } state_t;

endpackage

// File: rtl/fitness_eval_ctrl_if.sv
// HPS/evolved-circuit side bundle of the fitness sequencer; master is the HPS
// and circuit model, slave is the sequencer.
interface fitness_eval_ctrl_if
    import fitness_eval_pkg::*;
#(
    parameter int NUM_SEQ = 32,
    parameter int NUM_OUT = 8
);
    logic                       start_processing_chrom;
    logic                       done_processing_feedback;
    logic [SEQ_W-1:0]           sequences_to_process;
    logic [NUM_SEQ*SEQ_W-1:0]   input_sequence_flat;
    logic [NUM_SEQ*SEQ_W-1:0]   expected_output_flat;
    logic [NUM_SEQ*SEQ_W-1:0]   valid_output_flat;
    logic [NUM_OUT-1:0]         circ_out;
    logic [SEQ_W-1:0]           circ_in;
    logic                       chrom_load;
    logic                       ready_to_process;
    logic                       done_processing_chrom;
    logic [NUM_OUT*CNT_W-1:0]   error_sum_flat;

    modport master (
        output start_processing_chrom, done_processing_feedback, sequences_to_process,
               input_sequence_flat, expected_output_flat, valid_output_flat, circ_out,
        input  circ_in, chrom_load, ready_to_process, done_processing_chrom, error_sum_flat
    );

    modport slave (
        input  start_processing_chrom, done_processing_feedback, sequences_to_process,
               input_sequence_flat, expected_output_flat, valid_output_flat, circ_out,
        output circ_in, chrom_load, ready_to_process, done_processing_chrom, error_sum_flat
    );
endinterface

// File: rtl/fitness_eval_ctrl_seq_error_accum.sv
// Bank of per-output saturating error counters; clr has priority over en.
// Updates one cycle after a scored sample, never back-pressures.
module seq_error_accum
    import fitness_eval_pkg::*;
#(
    parameter int NUM_OUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic [NUM_OUT-1:0]       mismatch,
    output logic [NUM_OUT*CNT_W-1:0] error_sum_flat
);
    logic [CNT_W-1:0] sum_q [NUM_OUT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_OUT; j++) sum_q[j] <= '0;
        end else if (clr) begin
            for (int j = 0; j < NUM_OUT; j++) sum_q[j] <= '0;
        end else if (en) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (mismatch[j] && sum_q[j] != ERR_MAX) sum_q[j] <= sum_q[j] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_flat
        assign error_sum_flat[g*CNT_W +: CNT_W] = sum_q[g];
    end

endmodule

// File: rtl/fitness_eval_ctrl.sv
// Sequences one chromosome evaluation: load pulse, SETTLE-cycle apply, masked score.
// done at start+2+n*(SETTLE+1); HPS level handshake, RELEASE blocks stale re-trigger.
module fitness_eval_ctrl
    import fitness_eval_pkg::*;
#(
    parameter int NUM_SEQ = NUM_SEQ_DEF,
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    fitness_eval_ctrl_if.slave bus
);
    localparam int IDX_BITS = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
    localparam int N_BITS   = IDX_BITS + 1;

    state_t              state, state_nxt;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] idx_inc;
    logic [N_BITS-1:0]   n_q;
    logic [N_BITS-1:0]   n_load;
    logic [CNT_W-1:0]    cnt;
    logic [SEQ_W-1:0]    circ_in_q;
    logic [SEQ_W-1:0]    exp_word;
    logic [SEQ_W-1:0]    val_word;
    logic [NUM_OUT-1:0]  mismatch;
    logic                last_seq;
    logic                ready, done, load_pulse;

    function automatic logic [SEQ_W-1:0] word_at(input logic [NUM_SEQ*SEQ_W-1:0] flat,
                                                 input logic [IDX_BITS-1:0] k);
        return flat[SEQ_W*k +: SEQ_W];
    endfunction

    // Full 32-bit compare so huge counts clamp instead of wrapping.
    assign n_load   = (bus.sequences_to_process > SEQ_W'(NUM_SEQ)) ? N_BITS'(NUM_SEQ)
                                                                    : bus.sequences_to_process[N_BITS-1:0];
    assign idx_inc  = idx + 1'b1;
    assign last_seq = ({1'b0, idx} == (n_q - N_BITS'(1)));
    assign exp_word = word_at(bus.expected_output_flat, idx);
    assign val_word = word_at(bus.valid_output_flat, idx);
    assign mismatch = (bus.circ_out ^ exp_word[NUM_OUT-1:0]) & val_word[NUM_OUT-1:0];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.start_processing_chrom) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = (n_load == '0) ? S_DONE : S_APPLY;
            S_APPLY:   if (cnt == '0) state_nxt = S_SAMPLE;
            S_SAMPLE:  state_nxt = last_seq ? S_DONE : S_APPLY;
            S_DONE:    if (bus.done_processing_feedback) state_nxt = S_RELEASE;
            S_RELEASE: if (!bus.start_processing_chrom && !bus.done_processing_feedback)
                           state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready      = (state == S_IDLE);
        done       = (state == S_DONE);
        load_pulse = (state == S_LOAD);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            circ_in_q <= '0;
            idx       <= '0;
            n_q       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    idx <= '0;
                    n_q <= n_load;
                    if (n_load != '0) begin
                        circ_in_q <= word_at(bus.input_sequence_flat, '0);
                        cnt       <= CNT_W'(SETTLE - 1);
                    end
                end
                S_APPLY: if (cnt != '0) cnt <= cnt - 1'b1;
                S_SAMPLE: if (!last_seq) begin
                    idx       <= idx_inc;
                    circ_in_q <= word_at(bus.input_sequence_flat, idx_inc);
                    cnt       <= CNT_W'(SETTLE - 1);
                end
                default: ;
            endcase
        end
    end

    seq_error_accum #(.NUM_OUT(NUM_OUT)) u_accum (
        .clk            (clk_clk),
        .rst            (reset_reset),
        .clr            (load_pulse),
        .en             (state == S_SAMPLE),
        .mismatch       (mismatch),
        .error_sum_flat (bus.error_sum_flat)
    );

    assign bus.circ_in               = circ_in_q;
    assign bus.chrom_load            = load_pulse;
    assign bus.ready_to_process      = ready;
    assign bus.done_processing_chrom = done;

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Directed vector bench for fitness_eval_ctrl with an echo/stuck circuit model.
module tb_fitness_eval_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic echo = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] in_words [32];

    always #5 clk = ~clk;

    fitness_eval_ctrl_if #(.NUM_SEQ(32), .NUM_OUT(8)) bus ();

    fitness_eval_ctrl #(.NUM_SEQ(32), .NUM_OUT(8), .SETTLE(4)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus)
    );

    // Evolved-circuit stand-in: echo the low input byte, or stuck at zero.
    always_comb bus.circ_out = echo ? bus.circ_in[7:0] : 8'h00;

    typedef struct {
        logic [31:0]      n;
        logic             echo;
        logic [7:0]       pat_e, pat_o, val_e, val_o;
        logic [7:0][7:0]  es;
        int               lat;
    } vec_t;

    function automatic vec_t mk(logic [31:0] n, logic e, logic [7:0] pe, logic [7:0] po,
                                logic [7:0] ve, logic [7:0] vo, logic [63:0] es, int lat);
        vec_t v;
        v.n = n; v.echo = e; v.pat_e = pe; v.pat_o = po;
        v.val_e = ve; v.val_o = vo; v.es = es; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sum_at(int j);
        logic [255:0] f;
        f = bus.error_sum_flat;
        return f[32*j +: 32];
    endfunction

    task automatic load_vec(input vec_t v);
        logic [31:0] r;
        logic [7:0]  base, pat, val;
        echo = v.echo;
        bus.sequences_to_process = v.n;
        for (int k = 0; k < 32; k++) begin
            in_words[k] = 32'h5A00_0000 + k * 32'h0101_0011;
            r    = $urandom();
            base = v.echo ? in_words[k][7:0] : 8'h00;
            pat  = (k % 2 == 0) ? v.pat_e : v.pat_o;
            val  = (k % 2 == 0) ? v.val_e : v.val_o;
            bus.input_sequence_flat[32*k +: 32]  = in_words[k];
            bus.expected_output_flat[32*k +: 32] = {r[31:8], base ^ pat};
            bus.valid_output_flat[32*k +: 32]    = {24'hFF_FFFF, val};
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int loads, both, lat, n_eff;
        bit seen;
        load_vec(v);
        n_eff = (v.n > 32) ? 32 : int'(v.n);
        loads = 0; both = 0; lat = 0; seen = 0;
        @(negedge clk);
        bus.start_processing_chrom = 1'b1;
        for (int c = 1; c <= 400 && !seen; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.start_processing_chrom = 1'b0;
            if (bus.chrom_load) loads++;
            if (bus.ready_to_process && bus.done_processing_chrom) both++;
            if (bus.done_processing_chrom) begin seen = 1; lat = c; end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_chrom_load_pulses"}, loads, 32'd1);
        chk({tag, "_ready_and_done"}, both, 32'd0);
        for (int j = 0; j < 8; j++)
            chk($sformatf("%s_error_sum%0d", tag, j), sum_at(j), 32'(v.es[j]));
        if (n_eff > 0) chk({tag, "_circ_in_frozen"}, bus.circ_in, in_words[n_eff-1]);
        @(negedge clk);
        bus.done_processing_feedback = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_release_done_low"}, 32'(bus.done_processing_chrom), 32'd0);
        @(negedge clk);
        bus.done_processing_feedback = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_back_to_idle"}, 32'(bus.ready_to_process), 32'd1);
    endtask

    vec_t vecs[9];

    initial begin
        int loads;
        bit seen;
        vecs[0] = mk(32'd3,  1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 64'h0, 17);
        vecs[1] = mk(32'd2,  1'b0, 8'h81, 8'h01, 8'hFF, 8'hFF, 64'h0100000000000002, 12);
        vecs[2] = mk(32'd2,  1'b0, 8'h81, 8'h01, 8'h80, 8'h00, 64'h0100000000000000, 12);
        vecs[3] = mk(32'd0,  1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 64'h0, 2);
        vecs[4] = mk(32'd40, 1'b1, 8'h03, 8'h00, 8'hFF, 8'hFF, 64'h0000000000001010, 162);
        vecs[5] = mk(32'd5,  1'b1, 8'h10, 8'h24, 8'hF0, 8'h0F, 64'h0000000300020000, 27);
        vecs[6] = mk(32'd1,  1'b0, 8'hFF, 8'h00, 8'h5A, 8'h00, 64'h0001000101000100, 7);
        vecs[7] = mk(32'd32, 1'b0, 8'h00, 8'h80, 8'hFF, 8'hFF, 64'h1000000000000000, 162);
        vecs[8] = mk(32'h0001_0003, 1'b0, 8'h00, 8'h80, 8'hFF, 8'hFF, 64'h1000000000000000, 162);

        bus.start_processing_chrom   = 1'b0;
        bus.done_processing_feedback = 1'b0;
        load_vec(vecs[0]);
        #1;
        chk("reset_ready", 32'(bus.ready_to_process), 32'd1);
        chk("reset_done", 32'(bus.done_processing_chrom), 32'd0);
        chk("reset_chrom_load", 32'(bus.chrom_load), 32'd0);
        chk("reset_circ_in", bus.circ_in, 32'd0);
        chk("reset_sum0", sum_at(0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Start held high through DONE must not retrigger.
        load_vec(vecs[6]);
        @(negedge clk);
        bus.start_processing_chrom = 1'b1;
        seen = 0;
        for (int c = 1; c <= 400 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus.done_processing_chrom) seen = 1;
        end
        chk("hold_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        bus.done_processing_feedback = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_done", 32'(bus.done_processing_chrom), 32'd0);
        @(negedge clk);
        bus.done_processing_feedback = 1'b0;
        loads = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.chrom_load) loads++;
        end
        chk("hold_stays_release", 32'(bus.ready_to_process), 32'd0);
        chk("hold_no_rerun", loads, 32'd0);
        @(negedge clk);
        bus.start_processing_chrom = 1'b0;
        @(posedge clk); #1;
        chk("hold_idle_after_drop", 32'(bus.ready_to_process), 32'd1);

        // Asynchronous reset while applying sequence 5.
        load_vec(mk(32'd10, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 64'h0, 0));
        @(negedge clk);
        bus.start_processing_chrom = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.start_processing_chrom = 1'b0;
        end
        chk("rst_pre_sum0", sum_at(0), 32'd5);
        chk("rst_pre_circ_in", bus.circ_in, in_words[5]);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_sum0", sum_at(0), 32'd0);
        chk("rst_mid_sum7", sum_at(7), 32'd0);
        chk("rst_mid_circ_in", bus.circ_in, 32'd0);
        chk("rst_mid_done", 32'(bus.done_processing_chrom), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_after_ready", 32'(bus.ready_to_process), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
